// File: rtl/ecp5_phase_stepper.sv
// ecp5_phase_stepper: drives EHXPLLL dynamic phase-adjust ports from a valid/ready request.
// Optional: define PHASE_STEPPER_LOCK_WAIT_EN to gate acceptance and inter-step gaps on pll_locked.
module ecp5_phase_stepper #(
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        pll_locked,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_sel,
    input  logic        req_dir,
    input  logic [7:0]  req_steps,
    output logic        busy,
    output logic        done,
    output logic [1:0]  phasesel,
    output logic        phasedir,
    output logic        phasestep,
    output logic        phaseloadreg,
    output logic [11:0] phase_pos
);

    localparam int MAX_SP = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int MAX_CYCLES = (MAX_SP > GAP_CYCLES) ? MAX_SP : GAP_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        GAP,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0] cnt;
    logic [7:0]    remaining;
    logic          lock_ok;
    logic          accept;
    logic          gap_end;
    logic          count_en;
    logic          step_taken;
    logic [3:0]    field_base;
    logic [2:0]    field_cur;
    logic [2:0]    field_nxt;

`ifdef PHASE_STEPPER_LOCK_WAIT_EN
    assign lock_ok = pll_locked;
`else
    logic unused_lock;
    assign lock_ok     = 1'b1;
    assign unused_lock = pll_locked;
`endif

    assign accept  = (state == IDLE) && req_valid && req_ready;
    assign gap_end = (state == GAP) && (cnt == GAP_LAST);

    // phasesel doubles as the latched target; 3 bits of phase_pos per output
    assign field_base = {2'b00, phasesel} * 4'd3;
    assign field_cur  = phase_pos[field_base +: 3];
    assign field_nxt  = phasedir ? field_cur + 3'd1 : field_cur - 3'd1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        count_en   = 1'b0;
        step_taken = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (req_steps == 8'd0) ? DONE : SETUP;
                end
            end
            SETUP: begin
                count_en = 1'b1;
                if (cnt == SETUP_LAST) begin
                    state_nxt = PULSE;
                end
            end
            PULSE: begin
                count_en = 1'b1;
                if (cnt == PULSE_LAST) begin
                    state_nxt  = GAP;
                    step_taken = 1'b1;
                end
            end
            GAP: begin
                count_en = !gap_end;
                // without lock the gap stretches here, with PHASESTEP still high
                if (gap_end && lock_ok) begin
                    state_nxt = (remaining != 8'd0) ? PULSE : DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            remaining <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            phasesel  <= 2'd0;
            phasedir  <= 1'b1;
            phasestep <= 1'b1;
            phase_pos <= '0;
        end else begin
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (count_en) begin
                cnt <= cnt + CW'(1);
            end

            if (accept) begin
                phasesel  <= req_sel;
                phasedir  <= req_dir;
                remaining <= req_steps;
            end

            if (step_taken) begin
                remaining <= remaining - 8'd1;
                phase_pos[field_base +: 3] <= field_nxt;
            end

            req_ready <= (state_nxt == IDLE) && lock_ok;
            busy      <= (state_nxt != IDLE);
            done      <= (state_nxt == DONE);
            phasestep <= (state_nxt != PULSE);
        end
    end

    assign phaseloadreg = 1'b1;

endmodule

// File: tb/tb_ecp5_phase_stepper.sv
// tb_ecp5_phase_stepper: scoreboard bench for ecp5_phase_stepper.
// Honours PHASE_STEPPER_LOCK_WAIT_EN to select lock-wait expectations.
module tb_ecp5_phase_stepper;

    localparam int S = 2;
    localparam int P = 4;
    localparam int G = 4;
`ifdef PHASE_STEPPER_LOCK_WAIT_EN
    localparam bit LOCK_EN    = 1'b1;
    localparam int LOCK_EXTRA = 10;
`else
    localparam bit LOCK_EN    = 1'b0;
    localparam int LOCK_EXTRA = 0;
`endif

    logic        clock = 1'b0;
    logic        resetn;
    logic        pll_locked;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_sel;
    logic        req_dir;
    logic [7:0]  req_steps;
    logic        busy;
    logic        done;
    logic [1:0]  phasesel;
    logic        phasedir;
    logic        phasestep;
    logic        phaseloadreg;
    logic [11:0] phase_pos;

    typedef struct {
        int          done_cyc;
        logic [11:0] pos;
        int          pulses;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] mpos[4];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         last_acc = 0;
    int         last_done = 0;

    ecp5_phase_stepper #(
        .SETUP_CYCLES(S),
        .PULSE_CYCLES(P),
        .GAP_CYCLES(G)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .pll_locked(pll_locked),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_sel(req_sel),
        .req_dir(req_dir),
        .req_steps(req_steps),
        .busy(busy),
        .done(done),
        .phasesel(phasesel),
        .phasedir(phasedir),
        .phasestep(phasestep),
        .phaseloadreg(phaseloadreg),
        .phase_pos(phase_pos)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [11:0] model_pos();
        logic [11:0] r;
        for (int i = 0; i < 4; i++) r[i*3 +: 3] = mpos[i];
        return r;
    endfunction

    task automatic step_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic run_req(input logic [1:0] sel, input logic dir,
                           input logic [7:0] steps, input bit noise,
                           input bit drop);
        exp_t e;
        exp_t got;
        int   n_acc, budget, low_len, high_len, npulse, first_low;
        int   drop_cnt, bad_hs, gap_exp;
        bit   acc, prev_ps, dropping;
        req_sel   = sel;
        req_dir   = dir;
        req_steps = steps;
        req_valid = 1'b1;
        acc    = 1'b0;
        budget = 0;
        while (!acc && budget < 200) begin
            acc = req_ready;
            step_cycle();
            budget++;
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: req_ready=%0b want 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        n_acc    = cyc;
        last_acc = n_acc;
        req_valid = noise;
        if (noise) begin
            req_sel   = ~sel;
            req_dir   = ~dir;
            req_steps = 8'd5;
        end
        mpos[sel] = dir ? mpos[sel] + 3'(steps) : mpos[sel] - 3'(steps);
        e.pos      = model_pos();
        e.pulses   = steps;
        e.done_cyc = n_acc + 1;
        if (steps != 0) e.done_cyc += S + int'(steps) * (P + G);
        if (drop && steps > 1) e.done_cyc += LOCK_EXTRA;
        sb.push_back(e);

        prev_ps   = 1'b1;
        low_len   = 0;
        high_len  = 0;
        npulse    = 0;
        first_low = -1;
        drop_cnt  = 0;
        dropping  = 1'b0;
        bad_hs    = 0;
        budget    = 0;
        while (!done && budget < 3000) begin
            if (!busy || req_ready) bad_hs++;
            if (!phasestep) begin
                if (prev_ps) begin
                    npulse++;
                    if (first_low < 0) first_low = cyc + 1;
                    if (npulse > 1) begin
                        gap_exp = G + ((drop && npulse == 2) ? LOCK_EXTRA : 0);
                        n_cmp++;
                        if (high_len != gap_exp) begin
                            n_err++;
                            $display("FAIL gap_len: got %0d want %0d", high_len, gap_exp);
                        end
                    end
                end
                low_len++;
            end else begin
                if (!prev_ps) begin
                    n_cmp++;
                    if (low_len != P) begin
                        n_err++;
                        $display("FAIL pulse_len: got %0d want %0d", low_len, P);
                    end
                    low_len  = 0;
                    high_len = 0;
                end
                high_len++;
            end
            if (dropping) begin
                drop_cnt++;
                if (drop_cnt == 10) begin
                    pll_locked = 1'b1;
                    dropping   = 1'b0;
                end
            end else if (drop && npulse == 1 && phasestep && high_len == G
                         && drop_cnt == 0) begin
                pll_locked = 1'b0;
                dropping   = 1'b1;
            end
            prev_ps = phasestep;
            step_cycle();
            budget++;
        end
        req_valid  = 1'b0;
        pll_locked = 1'b1;
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL done_timeout: done=%0b want 1", done);
            return;
        end
        last_done = cyc;
        got = sb.pop_front();
        if (cyc + 1 !== got.done_cyc) begin
            n_err++;
            $display("FAIL done_cycle: got %0d want %0d", cyc + 1, got.done_cyc);
        end
        n_cmp++;
        if (npulse !== got.pulses) begin
            n_err++;
            $display("FAIL pulse_count: got %0d want %0d", npulse, got.pulses);
        end
        n_cmp++;
        if (phase_pos !== got.pos) begin
            n_err++;
            $display("FAIL phase_pos: got %h want %h", phase_pos, got.pos);
        end
        n_cmp++;
        if (phasesel !== sel || phasedir !== dir) begin
            n_err++;
            $display("FAIL sel_dir: got %0d/%0b want %0d/%0b", phasesel, phasedir, sel, dir);
        end
        n_cmp++;
        if (bad_hs != 0) begin
            n_err++;
            $display("FAIL busy_ready: got %0d bad cycles want 0", bad_hs);
        end
        if (steps != 0) begin
            n_cmp++;
            if (first_low !== n_acc + 1 + S) begin
                n_err++;
                $display("FAIL first_pulse: got %0d want %0d", first_low, n_acc + 1 + S);
            end
        end
        step_cycle();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL post_done: got d%0b b%0b r%0b want d0 b0 r1", done, busy, req_ready);
        end
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        pll_locked = 1'b1;
        req_valid  = 1'b0;
        req_sel    = 2'd0;
        req_dir    = 1'b0;
        req_steps  = 8'd0;
        for (int i = 0; i < 4; i++) mpos[i] = 3'd0;
        #13;
        n_cmp++;
        if ({phasestep, phaseloadreg, phasedir} !== 3'b111) begin
            n_err++;
            $display("FAIL reset_pins: got %b want 111", {phasestep, phaseloadreg, phasedir});
        end
        n_cmp++;
        if (phasesel !== 2'd0 || phase_pos !== 12'd0) begin
            n_err++;
            $display("FAIL reset_pos: got %0d/%h want 0/000", phasesel, phase_pos);
        end
        n_cmp++;
        if (req_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hs: got r%0b b%0b d%0b want 0", req_ready, busy, done);
        end
        step_cycle();
        resetn = 1'b1;
        step_cycle();
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset: got %0b want 1", req_ready);
        end
    endtask

    task automatic test_wrap();
        run_req(2'd0, 1'b0, 8'd1, 1'b0, 1'b0);
    endtask

    task automatic test_steps();
        run_req(2'd1, 1'b1, 8'd3, 1'b1, 1'b0);
    endtask

    task automatic test_zero_steps();
        run_req(2'd2, 1'b1, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int d;
        run_req(2'd3, 1'b0, 8'd2, 1'b0, 1'b0);
        d = last_done;
        run_req(2'd3, 1'b0, 8'd7, 1'b0, 1'b0);
        n_cmp++;
        if (last_acc !== d + 2) begin
            n_err++;
            $display("FAIL b2b_accept: got %0d want %0d", last_acc, d + 2);
        end
    endtask

    task automatic test_lock();
        logic exp_ready;
        exp_ready  = ~LOCK_EN;
        pll_locked = 1'b0;
        step_cycle();
        step_cycle();
        n_cmp++;
        if (req_ready !== exp_ready) begin
            n_err++;
            $display("FAIL ready_unlocked: got %0b want %0b", req_ready, exp_ready);
        end
`ifdef PHASE_STEPPER_LOCK_WAIT_EN
        req_sel   = 2'd2;
        req_dir   = 1'b1;
        req_steps = 8'd1;
        req_valid = 1'b1;
        repeat (3) step_cycle();
        req_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || phase_pos !== model_pos()) begin
            n_err++;
            $display("FAIL unlocked_ignored: got b%0b %h want b0 %h", busy, phase_pos, model_pos());
        end
`endif
        pll_locked = 1'b1;
        step_cycle();
        run_req(2'd3, 1'b1, 8'd2, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int budget;
        bit acc;
        req_sel   = 2'd2;
        req_dir   = 1'b0;
        req_steps = 8'd2;
        req_valid = 1'b1;
        acc       = 1'b0;
        budget    = 0;
        while (!acc && budget < 200) begin
            acc = req_ready;
            step_cycle();
            budget++;
        end
        req_valid = 1'b0;
        budget    = 0;
        while (phasestep && budget < 50) begin
            step_cycle();
            budget++;
        end
        n_cmp++;
        if (phasestep !== 1'b0) begin
            n_err++;
            $display("FAIL mid_pulse_reached: got %0b want 0", phasestep);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (phasestep !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_hs: got ps%0b b%0b d%0b r%0b want 1000",
                     phasestep, busy, done, req_ready);
        end
        n_cmp++;
        if (phase_pos !== 12'd0 || phasesel !== 2'd0 || phasedir !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset_pos: got %h/%0d/%0b want 000/0/1", phase_pos, phasesel, phasedir);
        end
        for (int i = 0; i < 4; i++) mpos[i] = 3'd0;
        sb.delete();
        step_cycle();
        resetn = 1'b1;
        step_cycle();
        run_req(2'd2, 1'b1, 8'd1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_steps();
        test_zero_steps();
        test_back_to_back();
        test_lock();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ecp5_phase_stepper.md
# ecp5_phase_stepper

Sequential controller that drives the dynamic phase-adjust ports of an ECP5 EHXPLLL (PHASESEL, PHASEDIR, PHASESTEP, PHASELOADREG) from a simple valid/ready request interface. It sits in the clock-generation area next to the PLL wrapper, in the PLL input clock domain, and replaces the constant tie-offs on those ports. It sequences setup, step pulses and inter-step gaps, and tracks the resulting phase position of each PLL output.

## Interface
- SETUP_CYCLES, default 2: cycles PHASESEL/PHASEDIR are stable before the first step pulse; minimum 1.
- PULSE_CYCLES, default 4: cycles PHASESTEP is held low per step; minimum 1.
- GAP_CYCLES, default 4: cycles PHASESTEP is held high after each pulse; minimum 1.

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  PLL reference clock (same clock as the PLL CLKI).
- resetn  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL LOCK output.
- req_valid  in  1  step request valid.
- req_ready  out  1  controller can accept a request.
- req_sel  in  2  target output: 0=CLKOP, 1=CLKOS, 2=CLKOS2, 3=CLKOS3.
- req_dir  in  1  1 = advance, 0 = delay.
- req_steps  in  8  number of 45° steps, 0–255.
- busy  out  1  request in progress.
- done  out  1  one-cycle completion pulse.
- phasesel  out  2  to EHXPLLL PHASESEL[1:0].
- phasedir  out  1  to EHXPLLL PHASEDIR.
- phasestep  out  1  to EHXPLLL PHASESTEP; idle high, active low.
- phaseloadreg  out  1  to EHXPLLL PHASELOADREG; held high.
- phase_pos  out  12  tracked step position, 3 bits per output; [2:0] is CLKOP and [11:9] is CLKOS3.

## Operation
- States: IDLE, SETUP, PULSE, GAP, DONE.
- Reset values: state IDLE, req_ready 0, busy 0, done 0, phasesel 0, phasedir 1, phasestep 1, phaseloadreg 1, phase_pos 0.
- IDLE:
  - req_ready is 1, gated by pll_locked when the lock-wait feature is compiled in (see Configuration).
  - On req_valid && req_ready, latch sel, dir and steps, then drive phasesel/phasedir from the latched values.
  - If steps = 0, go to DONE. Otherwise go to SETUP.
- SETUP: hold SETUP_CYCLES cycles, then go to PULSE.
- PULSE: phasestep = 0 for PULSE_CYCLES cycles, then go to GAP.
- GAP:
  - phasestep = 1 for GAP_CYCLES cycles.
  - On the first GAP cycle, update phase_pos[sel]: +1 if dir = 1, −1 if dir = 0, modulo 8 (7+1 wraps to 0, 0−1 wraps to 7).
  - Decrement the remaining-step count. At the end of the gap, go to PULSE if remaining > 0, else go to DONE.
- DONE: done = 1 for one cycle, then go to IDLE.
- busy = 1 in every state except IDLE.
- req_ready = 0 whenever busy = 1.
- Inputs req_* are ignored outside IDLE.
- phasesel/phasedir keep their last driven values after completion.
- phaseloadreg is constant 1; loading is not used.
- resetn asserted mid-operation: all outputs return to reset values immediately (asynchronously), including phasestep = 1, which ends any pulse in progress. phase_pos resets to 0.

## Timing
- Request accepted at edge N: busy = 1 from cycle N+1.
- steps = n > 0:
  - first phasestep low at cycle N+1+SETUP_CYCLES;
  - done at cycle N+1+SETUP_CYCLES+n·(PULSE_CYCLES+GAP_CYCLES);
  - req_ready = 1 again the cycle after done.
- steps = 0: done at cycle N+1, with no phasestep activity.
- All outputs are registered; no combinational path from inputs to outputs.
- Back-to-back requests: a new request can be accepted on the first IDLE cycle after DONE.

## Configuration
- PHASE_STEPPER_LOCK_WAIT_EN defined:
  - req_ready additionally requires pll_locked = 1.
  - If pll_locked drops while in GAP, the FSM holds at the end of the gap (phasestep stays high) until pll_locked returns, then continues.
  - A pulse already in progress always completes.
- Not defined: pll_locked is ignored; sequencing proceeds unconditionally.

## Test plan
- Reset: hold resetn = 0 → phasestep = 1, phaseloadreg = 1, phasedir = 1, phasesel = 0, phase_pos = 0, req_ready = 0; release with pll_locked = 1 → req_ready = 1 on the next cycle.
- Default parameters, request sel = 1, dir = 1, steps = 3 accepted at edge N → exactly 3 low pulses of 4 cycles each, separated by 4 high cycles; done at N+27; phase_pos[5:3] = 3.
- Request sel = 0, dir = 0, steps = 1 from phase_pos[2:0] = 0 → phase_pos[2:0] = 7 (wrap); other fields unchanged.
- steps = 0 → done at N+1, phasestep never low, phase_pos unchanged.
- With PHASE_STEPPER_LOCK_WAIT_EN defined:
  - pll_locked = 0 in IDLE → req_ready = 0 and req_valid is ignored.
  - pll_locked dropped during the gap of step 1 of 2 for 10 cycles → second pulse is delayed by 10 cycles, with 2 pulses in total.
- resetn asserted during PULSE → phasestep = 1 and busy = 0 immediately; after release the next request behaves normally.
